i2c_request_arbiter: RTL

//   Shares one I2C_Controller between NUM_REQ on-chip requesters, one transaction at a time.

---
 rtl/i2c_request_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/i2c_request_arbiter.sv
// i2c_request_arbiter: round-robin sharing of one I2C controller among NUM_REQ requesters with a per-transaction watchdog
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/addr/data/rw   per-requester request (flattened fields), held until req_done
//   req_done, req_err   one-cycle finish pulse to the granted requester, error flag on timeout
//   rsp_data            last read data
//   grant_id, busy      current/last granted requester, arbiter not idle
//   p_addr/p_data/p_rw/i_valid   transaction to the controller
//   o_valid/n_data/o_data        read completion, write completion, read data from the controller
module i2c_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int GW            = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_rw,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          req_err,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         p_addr,
    output logic [DATA_WIDTH-1:0]         p_data,
    output logic                          p_rw,
    output logic                          i_valid,
    input  logic                          o_valid,
    input  logic                          n_data,
    input  logic [DATA_WIDTH-1:0]         o_data
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d, grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rsp_q, rsp_d;
    logic                  rw_q, rw_d, valid_q, valid_d, err_q, err_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [31:0]           wd_q, wd_d;
    int                    win;
    logic                  fin, tmo;
    // Scan from the highest offset down so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        win = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) win = (int'(ptr_q) + k) % NUM_REQ;
    end
    // Only the completion signal matching the captured direction counts.
    assign fin = rw_q ? o_valid : n_data;
    assign tmo = TIMEOUT_CYCLES > 0 && wd_q == 32'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        valid_d = valid_q;
        err_d   = err_q;
        rsp_d   = rsp_q;
        wd_d    = wd_q;
        done_d  = '0;
        case (state_q)
            IDLE: if (|req_valid) begin
                state_d = BUSY;
                grant_d = GW'(win);
                addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                data_d  = req_data[win*DATA_WIDTH +: DATA_WIDTH];
                rw_d    = req_rw[win];
                valid_d = 1'b1;
                wd_d    = '0;
            end
            BUSY: begin
                wd_d = wd_q + 32'd1;
                // Completion beats a same-cycle timeout, so err only when no completion.
                if (fin || tmo) begin
                    state_d         = DONE;
                    valid_d         = 1'b0;
                    done_d[grant_q] = 1'b1;
                    err_d           = !fin;
                    rsp_d           = fin && rw_q ? o_data : rsp_q;
                    ptr_d           = GW'((int'(grant_q) + 1) % NUM_REQ);
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            wd_q    <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
        end
    end
    assign req_done = done_q;
    assign req_err  = err_q;
    assign rsp_data = rsp_q;
    assign grant_id = grant_q;
    assign busy     = state_q != IDLE;
    assign p_addr   = addr_q;
    assign p_data   = data_q;
    assign p_rw     = rw_q;
    assign i_valid  = valid_q;
endmodule
